// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encodings, the read-modify-write state enum and the
// default memory-window constants (top of stack and number of words below it).
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  localparam logic [31:0] DEFAULT_STACK_TOP   = 32'h7ffffffc;
  localparam int          DEFAULT_DEPTH_WORDS = 256;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte or halfword out of a
// little-endian memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata       in  32  word read from memory
//   addr_lo     in   2  byte offset within the word
//   size        in   2  access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   is_unsigned in   1  1 = zero-extend, 0 = sign-extend
//   data        out 32  aligned, extended result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[{addr_lo, 3'b000} +: 8];
    half_val = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = rdata;
    case (size)
      SIZE_BYTE: data = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
      SIZE_HALF: data = {{16{half_val[15] & ~is_unsigned}}, half_val};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed data memory.
// Loads and word stores are single-cycle and combinational; byte/half stores
// are a two-cycle read-modify-write (IDLE reads and stalls, RMW_WRITE writes
// the merged word). Misaligned or out-of-window requests are blocked and
// reported with a registered one-cycle fault pulse.
// Handshake: the unit has no ready; when stall=1 the datapath must hold the
// PC and the request inputs unchanged into the next cycle. In RMW_WRITE the
// request inputs are ignored and the write completes unconditionally.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_*                  request from the datapath
//   load_data              aligned/extended load result (combinational)
//   stall                  hold PC and request
//   fault, fault_addr      blocked-request pulse and last faulting address
//   mem_*                  word-aligned memory interface
//   fsm_state              debug view of the RMW state machine
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = DEFAULT_STACK_TOP,
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  fsm_state
);

  localparam logic [31:0] TOP_WORD = STACK_TOP >> 2;
  localparam logic [31:0] LOW_WORD = TOP_WORD - 32'(DEPTH_WORDS);

  lsu_state_e  state_q, state_d;
  logic [31:0] merged_q;
  logic [31:0] addr_q;
  logic [31:0] merge_word;
  logic [31:0] aligned_data;
  logic [31:0] word_idx;
  logic [31:0] word_addr;
  logic        aligned_ok;
  logic        in_range;
  logic        legal;
  logic        illegal_req;

  assign word_idx  = {2'b00, req_addr[31:2]};
  assign word_addr = {req_addr[31:2], 2'b00};
  assign in_range  = (word_idx >= LOW_WORD) && (word_idx <= TOP_WORD);
  assign legal     = aligned_ok && in_range;
  // Faults are only raised for requests the unit actually examines (IDLE).
  assign illegal_req = (state_q == IDLE) && req_valid && !legal;
  assign fsm_state   = state_q;

  always_comb begin
    aligned_ok = 1'b0;
    case (req_size)
      SIZE_BYTE: aligned_ok = 1'b1;
      SIZE_HALF: aligned_ok = (req_addr[0] == 1'b0);
      SIZE_WORD: aligned_ok = (req_addr[1:0] == 2'b00);
      default:   aligned_ok = 1'b0;
    endcase
  end

  load_align u_load_align (
    .rdata       (mem_rdata),
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data        (aligned_data)
  );

  // Old word with the target lanes replaced by the low lanes of the store data.
  always_comb begin
    merge_word = mem_rdata;
    if (req_size == SIZE_BYTE) begin
      merge_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end else begin
      merge_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    mem_addr  = word_addr;
    mem_wdata = req_wdata;
    load_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid && legal) begin
          if (!req_write) begin
            mem_read  = 1'b1;
            load_data = aligned_data;
          end else if (req_size == SIZE_WORD) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            state_d  = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = merged_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset dominates: no memory traffic and no stall, which also cancels
    // a pending RMW write.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
      merged_q   <= 32'h0;
      addr_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      fault   <= illegal_req;
      if (illegal_req) begin
        fault_addr <= req_addr;
      end
      if ((state_q == IDLE) && (state_d == RMW_WRITE)) begin
        merged_q <= merge_word;
        addr_q   <= word_addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of single-cycle vectors plus
// hand-written multi-cycle sequences for read-modify-write stores and reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic [31:0] fault_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_e  fsm_state;

  int tests_run;
  int tests_failed;

  logic [31:0] mem_arr [0:511];
  logic [31:0] last_fault;

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr[10:2]];

  always @(negedge clk) begin
    if (mem_write) mem_arr[mem_addr[10:2]] = mem_wdata;
  end

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .load_data    (load_data),
    .stall        (stall),
    .fault        (fault),
    .fault_addr   (fault_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fsm_state    (fsm_state)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] idx(input logic [31:0] a);
    return a[10:2];
  endfunction

  task automatic drive(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = s;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = SIZE_WORD;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_ld;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_fault;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic w, logic [1:0] s, logic u, logic [31:0] a,
                              logic [31:0] d, logic [31:0] p, logic [31:0] ld,
                              logic rd, logic wr, logic f, logic [31:0] m);
    vec_t v;
    v.name = n; v.wr = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d; v.pre = p;
    v.exp_ld = ld; v.exp_rd = rd; v.exp_wr = wr; v.exp_fault = f; v.exp_mem = m;
    return v;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_fault   = 32'h0;
    for (int i = 0; i < 512; i++) mem_arr[i] = 32'h0;

    //            name         wr    size       uns   addr          wdata         pre           exp_ld        rd    wr    flt   exp_mem
    vecs.push_back(mk("lw",     1'b0, SIZE_WORD, 1'b0, 32'h7ffffff8, 32'h0,        32'h11223344, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h11223344));
    vecs.push_back(mk("lb3",    1'b0, SIZE_BYTE, 1'b0, 32'h7ffffffb, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lbu3",   1'b0, SIZE_BYTE, 1'b1, 32'h7ffffffb, 32'h0,        32'h80FF7F01, 32'h00000080, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lh2",    1'b0, SIZE_HALF, 1'b0, 32'h7ffffffa, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lhu2",   1'b0, SIZE_HALF, 1'b1, 32'h7ffffffa, 32'h0,        32'h80FF7F01, 32'h000080FF, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lb0",    1'b0, SIZE_BYTE, 1'b0, 32'h7ffffff8, 32'h0,        32'h80FF7F01, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lb1",    1'b0, SIZE_BYTE, 1'b0, 32'h7ffffff9, 32'h0,        32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("lh0",    1'b0, SIZE_HALF, 1'b0, 32'h7ffffff8, 32'h0,        32'h80FF7F01, 32'h00007F01, 1'b1, 1'b0, 1'b0, 32'h80FF7F01));
    vecs.push_back(mk("sw",     1'b1, SIZE_WORD, 1'b0, 32'h7ffffff8, 32'hDEADBEEF, 32'h11223344, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk("lh_mis", 1'b0, SIZE_HALF, 1'b0, 32'h7ffffff9, 32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("lw_low", 1'b0, SIZE_WORD, 1'b0, 32'h7ffffbf8, 32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("lw_min", 1'b0, SIZE_WORD, 1'b0, 32'h7ffffbfc, 32'h0,        32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h12345678));
    vecs.push_back(mk("lw_mis", 1'b0, SIZE_WORD, 1'b0, 32'h7ffffffa, 32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("sz11",   1'b0, 2'b11,     1'b0, 32'h7ffffff8, 32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("lw_top", 1'b0, SIZE_WORD, 1'b0, 32'h7ffffffc, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5));
    vecs.push_back(mk("lw_hi",  1'b0, SIZE_WORD, 1'b0, 32'h80000000, 32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("sb_mis", 1'b1, SIZE_HALF, 1'b0, 32'h7ffffffb, 32'h0000FFFF, 32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
    vecs.push_back(mk("sw_low", 1'b1, SIZE_WORD, 1'b0, 32'h7ffffbf8, 32'hCAFEF00D, 32'h11223344, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344));
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n        = 1'b0;
    req_unsigned = 1'b0;
    idle_req();
    #1;
    // Reset with a sub-word store presented: nothing may reach memory.
    drive(1'b1, SIZE_BYTE, 1'b0, 32'h7ffffff9, 32'h000000AB);
    next_cycle();
    #3;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_state", {31'b0, fsm_state}, {31'b0, IDLE});
    next_cycle();
    rst_n = 1'b1;
    idle_req();
    #3;
    chk("idle_enables", {30'b0, mem_read, mem_write}, 32'h0);
    chk("idle_load_data", load_data, 32'h0);
    chk("post_rst_fault", {31'b0, fault}, 32'h0);
    next_cycle();

    // Table-driven single-cycle accesses.
    for (int i = 0; i < vecs.size(); i++) begin
      mem_arr[idx(vecs[i].addr)] = vecs[i].pre;
      drive(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      #3;
      chk({vecs[i].name, "_load_data"}, load_data, vecs[i].exp_ld);
      chk({vecs[i].name, "_mem_read"}, {31'b0, mem_read}, {31'b0, vecs[i].exp_rd});
      chk({vecs[i].name, "_mem_write"}, {31'b0, mem_write}, {31'b0, vecs[i].exp_wr});
      chk({vecs[i].name, "_stall"}, {31'b0, stall}, 32'h0);
      if (!vecs[i].exp_fault) begin
        chk({vecs[i].name, "_mem_addr"}, mem_addr, {vecs[i].addr[31:2], 2'b00});
      end
      if (vecs[i].exp_wr) begin
        chk({vecs[i].name, "_mem_wdata"}, mem_wdata, vecs[i].wdata);
      end
      next_cycle();
      idle_req();
      if (vecs[i].exp_fault) last_fault = vecs[i].addr;
      chk({vecs[i].name, "_fault"}, {31'b0, fault}, {31'b0, vecs[i].exp_fault});
      chk({vecs[i].name, "_fault_addr"}, fault_addr, last_fault);
      chk({vecs[i].name, "_mem"}, mem_arr[idx(vecs[i].addr)], vecs[i].exp_mem);
    end

    // Fault pulse lasts one cycle only.
    next_cycle();
    chk("fault_pulse_end", {31'b0, fault}, 32'h0);

    // sb: read+stall, then merged write with request inputs ignored.
    mem_arr[idx(32'h7ffffff8)] = 32'h11223344;
    drive(1'b1, SIZE_BYTE, 1'b0, 32'h7ffffff9, 32'h000000AB);
    #3;
    chk("sb_c1_stall", {31'b0, stall}, 32'h1);
    chk("sb_c1_read", {31'b0, mem_read}, 32'h1);
    chk("sb_c1_write", {31'b0, mem_write}, 32'h0);
    chk("sb_c1_addr", mem_addr, 32'h7ffffff8);
    next_cycle();
    idle_req();
    req_addr = 32'h00000013;
    #3;
    chk("sb_c2_state", {31'b0, fsm_state}, {31'b0, RMW_WRITE});
    chk("sb_c2_write", {31'b0, mem_write}, 32'h1);
    chk("sb_c2_read", {31'b0, mem_read}, 32'h0);
    chk("sb_c2_stall", {31'b0, stall}, 32'h0);
    chk("sb_c2_addr", mem_addr, 32'h7ffffff8);
    chk("sb_c2_wdata", mem_wdata, 32'h1122AB44);
    next_cycle();
    chk("sb_mem", mem_arr[idx(32'h7ffffff8)], 32'h1122AB44);
    drive(1'b0, SIZE_WORD, 1'b0, 32'h7ffffff8, 32'h0);
    #3;
    chk("sb_lw", load_data, 32'h1122AB44);
    next_cycle();
    idle_req();

    // Back-to-back sh: second request presented during RMW_WRITE, accepted after.
    mem_arr[idx(32'h7ffffff8)] = 32'h11223344;
    drive(1'b1, SIZE_HALF, 1'b0, 32'h7ffffffa, 32'h0000BEEF);
    #3;
    chk("sh1_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    drive(1'b1, SIZE_HALF, 1'b0, 32'h7ffffff8, 32'h0000CAFE);
    #3;
    chk("sh1_write", {31'b0, mem_write}, 32'h1);
    chk("sh1_wdata", mem_wdata, 32'hBEEF3344);
    chk("sh1_rmw_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    chk("sh1_mem", mem_arr[idx(32'h7ffffff8)], 32'hBEEF3344);
    chk("sh2_state", {31'b0, fsm_state}, {31'b0, IDLE});
    #3;
    chk("sh2_stall", {31'b0, stall}, 32'h1);
    chk("sh2_read", {31'b0, mem_read}, 32'h1);
    next_cycle();
    idle_req();
    #3;
    chk("sh2_write", {31'b0, mem_write}, 32'h1);
    chk("sh2_wdata", mem_wdata, 32'hBEEFCAFE);
    chk("sh2_rmw_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    chk("sh2_mem", mem_arr[idx(32'h7ffffff8)], 32'hBEEFCAFE);
    chk("sh2_fault", {31'b0, fault}, 32'h0);

    // Reset during RMW_WRITE cancels the write.
    mem_arr[idx(32'h7ffffff8)] = 32'h11223344;
    drive(1'b1, SIZE_BYTE, 1'b0, 32'h7ffffff8, 32'h00000055);
    #3;
    chk("rstrmw_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    chk("rstrmw_state", {31'b0, fsm_state}, {31'b0, RMW_WRITE});
    rst_n = 1'b0;
    idle_req();
    #3;
    chk("rstrmw_write", {31'b0, mem_write}, 32'h0);
    chk("rstrmw_stall0", {31'b0, stall}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    chk("rstrmw_idle", {31'b0, fsm_state}, {31'b0, IDLE});
    chk("rstrmw_mem", mem_arr[idx(32'h7ffffff8)], 32'h11223344);
    chk("rstrmw_fault_addr", fault_addr, 32'h0);
    next_cycle();
    chk("rstrmw_mem2", mem_arr[idx(32'h7ffffff8)], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
